// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the LSU, the DMA/loader port, the arbiter and dmem.
// Names are from the arbiter's point of view: i_* flow into it, o_* flow out.
`timescale 1ns/1ps
interface dmem_arbiter_if;
  logic        i_lsu_req;
  logic [15:0] i_lsu_addr;
  logic [31:0] i_lsu_wdata;
  logic        i_lsu_we;
  logic [2:0]  i_lsu_ctrl;
  logic        o_lsu_gnt;
  logic        o_lsu_rvalid;
  logic [31:0] o_lsu_rdata;
  logic        o_lsu_err;

  logic        i_dma_req;
  logic [15:0] i_dma_addr;
  logic [31:0] i_dma_wdata;
  logic        i_dma_we;
  logic [2:0]  i_dma_ctrl;
  logic        o_dma_gnt;
  logic        o_dma_rvalid;
  logic [31:0] o_dma_rdata;
  logic        o_dma_err;

  logic [15:0] o_mem_addr;
  logic [31:0] o_mem_st_data;
  logic        o_mem_wren;
  logic [2:0]  o_mem_control;
  logic [31:0] i_mem_rdata;

  modport slave (
    input  i_lsu_req, i_lsu_addr, i_lsu_wdata, i_lsu_we, i_lsu_ctrl,
    output o_lsu_gnt, o_lsu_rvalid, o_lsu_rdata, o_lsu_err,
    input  i_dma_req, i_dma_addr, i_dma_wdata, i_dma_we, i_dma_ctrl,
    output o_dma_gnt, o_dma_rvalid, o_dma_rdata, o_dma_err,
    output o_mem_addr, o_mem_st_data, o_mem_wren, o_mem_control,
    input  i_mem_rdata
  );

  modport master (
    output i_lsu_req, i_lsu_addr, i_lsu_wdata, i_lsu_we, i_lsu_ctrl,
    input  o_lsu_gnt, o_lsu_rvalid, o_lsu_rdata, o_lsu_err,
    output i_dma_req, i_dma_addr, i_dma_wdata, i_dma_we, i_dma_ctrl,
    input  o_dma_gnt, o_dma_rvalid, o_dma_rdata, o_dma_err,
    input  o_mem_addr, o_mem_st_data, o_mem_wren, o_mem_control,
    output i_mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port dmem arbiter: LSU has fixed priority, DMA is forced through after
// STARVE_MAX lost cycles. Responses return one cycle after the grant.
`timescale 1ns/1ps
module dmem_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int MEM_SIZE   = 1024
) (
  input  logic i_clk,
  input  logic i_rst_n,
  dmem_arbiter_if.slave bus
);

  logic [7:0]  r_wait_cnt;
  logic        w_force_dma;
  logic        w_dma_gnt;
  logic        w_lsu_gnt;
  logic [15:0] w_addr_p0;
  logic [31:0] w_wdata_p0;
  logic        w_we_p0;
  logic [2:0]  w_ctrl_p0;

  logic        r_lsu_vld_p1;
  logic [31:0] r_lsu_rdata_p1;
  logic        r_lsu_err_p1;
  logic        r_dma_vld_p1;
  logic [31:0] r_dma_rdata_p1;
  logic        r_dma_err_p1;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    if (v >= 8'(STARVE_MAX)) return 8'(STARVE_MAX);
    return v + 8'd1;
  endfunction

  function automatic logic [2:0] acc_bytes(input logic [1:0] size);
    case (size)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Last byte touched by the access must lie inside dmem.
  function automatic logic range_err(input logic [15:0] addr, input logic [1:0] size);
    logic [31:0] last;
    last = {16'b0, addr} + {29'b0, acc_bytes(size)} - 32'd1;
    return last >= 32'(MEM_SIZE);
  endfunction

  // ---- p0: grant and memory mux (combinational) ----
  always_comb begin
    w_force_dma = 1'b0;
    w_dma_gnt   = 1'b0;
    w_lsu_gnt   = 1'b0;
    w_addr_p0   = bus.i_lsu_addr;
    w_wdata_p0  = bus.i_lsu_wdata;
    w_we_p0     = bus.i_lsu_we;
    w_ctrl_p0   = bus.i_lsu_ctrl;
    if (i_rst_n) begin
      w_force_dma = bus.i_dma_req && (r_wait_cnt == 8'(STARVE_MAX));
      w_dma_gnt   = bus.i_dma_req && (w_force_dma || !bus.i_lsu_req);
      w_lsu_gnt   = bus.i_lsu_req && !w_dma_gnt;
    end
    if (w_dma_gnt) begin
      w_addr_p0  = bus.i_dma_addr;
      w_wdata_p0 = bus.i_dma_wdata;
      w_we_p0    = bus.i_dma_we;
      w_ctrl_p0  = bus.i_dma_ctrl;
    end
  end

  assign bus.o_lsu_gnt     = w_lsu_gnt;
  assign bus.o_dma_gnt     = w_dma_gnt;
  assign bus.o_mem_addr    = w_addr_p0;
  assign bus.o_mem_st_data = w_wdata_p0;
  assign bus.o_mem_control = w_ctrl_p0;
  assign bus.o_mem_wren    = w_we_p0 && (w_lsu_gnt || w_dma_gnt);

  // Counter clears whenever DMA is idle or served, so a dropped request never
  // carries stale credit into its next attempt.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || w_dma_gnt || !bus.i_dma_req) r_wait_cnt <= 8'd0;
    else                                         r_wait_cnt <= sat_inc(r_wait_cnt);
  end

  // ---- p1: registered responses ----
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_lsu_vld_p1   <= 1'b0;
      r_lsu_rdata_p1 <= 32'h0;
      r_lsu_err_p1   <= 1'b0;
      r_dma_vld_p1   <= 1'b0;
      r_dma_rdata_p1 <= 32'h0;
      r_dma_err_p1   <= 1'b0;
    end else begin
      r_lsu_vld_p1 <= w_lsu_gnt;
      r_dma_vld_p1 <= w_dma_gnt;
      if (w_lsu_gnt) begin
        r_lsu_rdata_p1 <= bus.i_lsu_we ? 32'h0 : bus.i_mem_rdata;
        r_lsu_err_p1   <= range_err(bus.i_lsu_addr, bus.i_lsu_ctrl[1:0]);
      end
      if (w_dma_gnt) begin
        r_dma_rdata_p1 <= bus.i_dma_we ? 32'h0 : bus.i_mem_rdata;
        r_dma_err_p1   <= range_err(bus.i_dma_addr, bus.i_dma_ctrl[1:0]);
      end
    end
  end

  assign bus.o_lsu_rvalid = r_lsu_vld_p1;
  assign bus.o_lsu_rdata  = r_lsu_rdata_p1;
  assign bus.o_lsu_err    = r_lsu_err_p1;
  assign bus.o_dma_rvalid = r_dma_vld_p1;
  assign bus.o_dma_rdata  = r_dma_rdata_p1;
  assign bus.o_dma_err    = r_dma_err_p1;

endmodule
